// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and constants for the cradle-motor PWM ramp sequencer and its level-to-duty mapper.
package pwm_ramp_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, STEADY, STOP} state_t;

  localparam int unsigned PERIODE_DEFAULT = 24000;
  localparam int unsigned NIVEAU_MAX      = 4;

  typedef logic [2:0]  niveau_t;
  typedef logic [15:0] duty_t;

  function automatic niveau_t clamp_niveau(input niveau_t doel);
    return (doel > niveau_t'(NIVEAU_MAX)) ? niveau_t'(NIVEAU_MAX) : doel;
  endfunction

endpackage

// File: rtl/periode_teller.sv
// Free-running PWM period counter: counts 0..PERIODE-1, flags the last count and pulses at count 0.
module periode_teller
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned PERIODE = PERIODE_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  output duty_t cnt,
  output logic  wrap,
  output logic  periode_start
);

  localparam duty_t LAST = duty_t'(PERIODE - 1);

  assign wrap = (cnt == LAST);

  // periode_start is registered from wrap so it lines up with the cycle where cnt is 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      periode_start <= 1'b0;
    end else begin
      cnt           <= wrap ? '0 : cnt + 16'd1;
      periode_start <= wrap;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/soft-stop level sequencer for the cradle motor; duty and level only change on period boundaries.
// Optional emergency stop input is enabled with `define PWM_NOODSTOP_EN.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned PERIODE       = PERIODE_DEFAULT,
  parameter int unsigned STAP_PERIODES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  doel_niveau,
  output logic [2:0]  niveau,
  input  logic [15:0] duty_in,
  output logic        pwm_out,
  output logic        periode_start,
  output logic        busy
`ifdef PWM_NOODSTOP_EN
  ,
  input  logic        noodstop
`endif
);

  localparam int SW = (STAP_PERIODES > 1) ? $clog2(STAP_PERIODES) : 1;
  typedef logic [SW-1:0] stap_t;
  localparam stap_t STAP_LAST = stap_t'(STAP_PERIODES - 1);

  state_t  state;
  duty_t   cnt;
  duty_t   compare;
  stap_t   stap_cnt;
  logic    wrap;
  niveau_t doel_c;
  logic    stap_klaar;

  assign doel_c     = clamp_niveau(doel_niveau);
  assign stap_klaar = (stap_cnt == STAP_LAST);

  periode_teller #(
    .PERIODE(PERIODE)
  ) u_periode_teller (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt          (cnt),
    .wrap         (wrap),
    .periode_start(periode_start)
  );

  // Everything except pwm_out moves only at the last count, so the mapper gets a full period to settle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      niveau   <= '0;
      compare  <= '0;
      stap_cnt <= '0;
      pwm_out  <= 1'b0;
      busy     <= 1'b0;
    end
`ifdef PWM_NOODSTOP_EN
    else if (noodstop) begin
      state    <= IDLE;
      niveau   <= '0;
      compare  <= '0;
      stap_cnt <= '0;
      pwm_out  <= 1'b0;
      busy     <= 1'b0;
    end
`endif
    else begin
      pwm_out <= (state != IDLE) && (cnt < compare);
      if (wrap) begin
        compare <= duty_in;
        case (state)
          IDLE: begin
            if (enable) begin
              state    <= RAMP;
              busy     <= 1'b1;
              niveau   <= '0;
              stap_cnt <= '0;
            end
          end
          RAMP: begin
            if (!enable) begin
              state    <= STOP;
              stap_cnt <= '0;
            end else if (niveau == doel_c) begin
              state    <= STEADY;
              busy     <= 1'b0;
              stap_cnt <= '0;
            end else if (stap_klaar) begin
              stap_cnt <= '0;
              niveau   <= (doel_c > niveau) ? niveau + 3'd1 : niveau - 3'd1;
            end else begin
              stap_cnt <= stap_cnt + stap_t'(1);
            end
          end
          STEADY: begin
            if (!enable) begin
              state    <= STOP;
              busy     <= 1'b1;
              stap_cnt <= '0;
            end else if (doel_c != niveau) begin
              state    <= RAMP;
              busy     <= 1'b1;
              stap_cnt <= '0;
            end
          end
          STOP: begin
            // re-enabling resumes the ramp from wherever the ramp-down has got to
            if (enable) begin
              state    <= RAMP;
              stap_cnt <= '0;
            end else if (stap_klaar) begin
              stap_cnt <= '0;
              if (niveau == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                niveau <= niveau - 3'd1;
              end
            end else begin
              stap_cnt <= stap_cnt + stap_t'(1);
            end
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            niveau   <= '0;
            stap_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer with PERIODE=100, STAP_PERIODES=2 and a scaled mapper stub.
module tb_pwm_ramp_sequencer;

  localparam int PER  = 100;
  localparam int ROWS = 49;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  doel_niveau = 3'd0;
  logic [2:0]  niveau;
  logic [15:0] duty_in;
  logic        pwm_out;
  logic        periode_start;
  logic        busy;
`ifdef PWM_NOODSTOP_EN
  logic        noodstop = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int hoog;
    int niv;
    int bsy;
  } exp_t;

  exp_t verwacht[$];

  always #5 clk = ~clk;

  // Mapper stub scaled to a 100-clock period
  always_comb begin
    duty_in = 16'd0;
    case (niveau)
      3'd0: duty_in = 16'd5;
      3'd1: duty_in = 16'd20;
      3'd2: duty_in = 16'd40;
      3'd3: duty_in = 16'd60;
      3'd4: duty_in = 16'd80;
      default: duty_in = 16'd0;
    endcase
  end

  pwm_ramp_sequencer #(
    .PERIODE(PER),
    .STAP_PERIODES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .doel_niveau  (doel_niveau),
    .niveau       (niveau),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .periode_start(periode_start),
    .busy         (busy)
`ifdef PWM_NOODSTOP_EN
    ,
    .noodstop     (noodstop)
`endif
  );

  // One row per period: inputs applied mid-period, then the expected high-time of that period
  // and the level/busy seen at the start of the next one. {enable, doel, hoog, niveau', busy'}
  int tab [0:ROWS-1][0:4] = '{
    '{0,0, 0,0,0}, '{0,0, 0,0,0}, '{0,0, 0,0,0},
    '{1,3, 0,0,1}, '{1,3, 5,0,1}, '{1,3, 5,1,1}, '{1,3, 5,1,1}, '{1,3,20,2,1},
    '{1,3,20,2,1}, '{1,3,40,3,1}, '{1,3,40,3,0}, '{1,3,60,3,0}, '{1,3,60,3,0},
    '{0,3,60,3,1}, '{0,3,60,3,1}, '{0,3,60,2,1}, '{0,3,60,2,1}, '{0,3,40,1,1},
    '{0,3,40,1,1}, '{0,3,20,0,1}, '{0,3,20,0,1}, '{0,3, 5,0,0}, '{0,3, 0,0,0},
    '{1,7, 0,0,1}, '{1,7, 5,0,1}, '{1,7, 5,1,1}, '{1,7, 5,1,1}, '{1,7,20,2,1},
    '{1,1,20,2,1}, '{1,1,40,1,1}, '{1,1,40,1,0},
    '{1,7,20,1,1}, '{1,7,20,1,1}, '{1,7,20,2,1}, '{1,7,20,2,1}, '{1,7,40,3,1},
    '{1,7,40,3,1}, '{1,7,60,4,1}, '{1,7,60,4,0}, '{1,7,80,4,0}, '{1,7,80,4,0},
    '{0,2,80,4,1}, '{1,2,80,4,1}, '{1,2,80,4,1}, '{1,2,80,3,1}, '{1,2,80,3,1},
    '{1,2,60,2,1}, '{1,2,60,2,0}, '{1,2,40,2,0}
  };

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    exp_t e;
    enable      = 1'(tab[idx][0]);
    doel_niveau = 3'(tab[idx][1]);
    e.idx  = idx;
    e.hoog = tab[idx][2];
    e.niv  = tab[idx][3];
    e.bsy  = tab[idx][4];
    verwacht.push_back(e);
  endtask

  task automatic waitPulse();
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (periode_start) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL periode_start_timeout: got no pulse required one within %0d clocks", 3 * PER);
  endtask

  // Monitor: accumulates pwm high-time per period and checks against the scoreboard at each boundary
  int  acc;
  int  cyc;
  bit  seen;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc  = 0;
      cyc  = 0;
      seen = 1'b0;
    end else begin
      acc += int'(pwm_out);
      cyc++;
      if (periode_start) begin
        if (seen) checkOutput("periode_len", cyc, PER);
        if (verwacht.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_boundary: got a boundary required none");
        end else begin
          e = verwacht.pop_front();
          checkOutput($sformatf("hoog_p%0d", e.idx), acc, e.hoog);
          checkOutput($sformatf("niveau_p%0d", e.idx), int'(niveau), e.niv);
          checkOutput($sformatf("busy_p%0d", e.idx), int'(busy), e.bsy);
        end
        acc  = 0;
        cyc  = 0;
        seen = 1'b1;
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    checkOutput("reset_niveau", int'(niveau), 0);
    checkOutput("reset_pwm", int'(pwm_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_periode_start", int'(periode_start), 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(0);
    for (int r = 1; r < ROWS; r++) begin
      waitPulse();
      repeat (37) @(negedge clk);
      applyStimulus(r);
    end
    waitPulse();
    repeat (37) @(negedge clk);
    checkOutput("steady_pwm_high", int'(pwm_out), 1);
`ifdef PWM_NOODSTOP_EN
    noodstop = 1'b1;
    @(negedge clk);
    checkOutput("nood_pwm", int'(pwm_out), 0);
    checkOutput("nood_niveau", int'(niveau), 0);
    checkOutput("nood_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    checkOutput("nood_hold_pwm", int'(pwm_out), 0);
    checkOutput("nood_hold_niveau", int'(niveau), 0);
    noodstop = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_pwm", int'(pwm_out), 0);
    checkOutput("midrst_niveau", int'(niveau), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_periode_start", int'(periode_start), 0);
    checkOutput("scoreboard_leftover", verwacht.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
